// File: rtl/freq_eq_pkg.sv
// Shared definitions for the frequency-domain equaliser: FSM encodings,
// RAM bank select codes, coefficient format and the Q-format
// round/saturate helper used by the complex multiplier.
package freq_eq_pkg;

  // Frame geometry and arithmetic widths
  localparam int SAMPLE_DEFAULT    = 8;
  localparam int N_BIT_DEFAULT     = 3;
  localparam int COEF_FRAC_DEFAULT = 10;
  localparam int DATA_W            = 32;
  localparam int PROD_W            = 65;

  // Sequencer states, one RAM access phase each
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CALC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // RAM bank selects shared with the DFT/iDFT stages
  localparam logic [1:0] BANK_OUT     = 2'b00;
  localparam logic [1:0] BANK_DFT     = 2'b01;
  localparam logic [1:0] BANK_IDFT_IN = 2'b10;

  // 1.0 in Q10 coefficient format
  localparam logic signed [DATA_W-1:0] COEF_UNITY = 32'sd1024;

  // Output clamp bounds, expressed at product width for comparison
  localparam logic signed [PROD_W-1:0] SAT_MAX = 65'sd2147483647;
  localparam logic signed [PROD_W-1:0] SAT_MIN = -65'sd2147483648;

  // Rounded and clamped result plus a flag telling whether the clamp fired
  typedef struct packed {
    logic              sat;
    logic [DATA_W-1:0] val;
  } sat_res_t;

  // Round half up, arithmetic shift by frac, then clamp to 32-bit signed
  function automatic sat_res_t round_sat(input logic signed [PROD_W-1:0] p,
                                         input int frac);
    logic signed [PROD_W-1:0] half;
    logic signed [PROD_W-1:0] r;
    sat_res_t                 res;
    half = 65'sd1 <<< (frac - 1);
    r    = (p + half) >>> frac;
    if (r > SAT_MAX) begin
      res.sat = 1'b1;
      res.val = SAT_MAX[DATA_W-1:0];
    end else if (r < SAT_MIN) begin
      res.sat = 1'b1;
      res.val = SAT_MIN[DATA_W-1:0];
    end else begin
      res.sat = 1'b0;
      res.val = r[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/freq_eq_cmul_q.sv
// Registered complex multiply (a+jb)*(c+jd) at full 65-bit precision,
// followed by round/shift/saturate back to 32-bit signed. The product
// register holds its value until the next load, so the rounded outputs
// stay stable for as long as a consumer needs them.
module freq_eq_cmul_q
  import freq_eq_pkg::*;
#(
  parameter int FRAC = COEF_FRAC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [DATA_W-1:0] c,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] res_re,
  output logic signed [DATA_W-1:0] res_im,
  output logic                     sat
);

  logic signed [PROD_W-1:0] p_re_r;
  logic signed [PROD_W-1:0] p_im_r;
  sat_res_t                 r_re_s;
  sat_res_t                 r_im_s;

  // Capture the full-width real and imaginary products on load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_re_r <= '0;
      p_im_r <= '0;
    end else if (load) begin
      p_re_r <= PROD_W'(a) * PROD_W'(c) - PROD_W'(b) * PROD_W'(d);
      p_im_r <= PROD_W'(a) * PROD_W'(d) + PROD_W'(b) * PROD_W'(c);
    end else begin
      p_re_r <= p_re_r;
      p_im_r <= p_im_r;
    end
  end

  // Scale the held products back to data format and flag any clamp
  always_comb begin
    r_re_s = round_sat(p_re_r, FRAC);
    r_im_s = round_sat(p_im_r, FRAC);
    res_re = $signed(r_re_s.val);
    res_im = $signed(r_im_s.val);
    sat    = r_re_s.sat | r_im_s.sat;
  end

endmodule

// File: rtl/freq_eq.sv
// Frequency-domain equaliser. Walks every bin of the DFT result bank,
// multiplies it by a programmable complex Q10 coefficient and writes the
// result to the iDFT input bank, four cycles per bin. done doubles as the
// iDFT start. Coefficients can only change while no frame is running.
module freq_eq
  import freq_eq_pkg::*;
#(
  parameter int sample           = SAMPLE_DEFAULT,
  parameter int n_bit_for_sample = N_BIT_DEFAULT,
  parameter int COEF_FRAC        = COEF_FRAC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic signed [DATA_W-1:0]    data_in_1,
  input  logic signed [DATA_W-1:0]    data_in_2,
  input  logic                        coef_we,
  input  logic [n_bit_for_sample-1:0] coef_addr,
  input  logic signed [DATA_W-1:0]    coef_re,
  input  logic signed [DATA_W-1:0]    coef_im,
  output logic                        done,
  output logic                        wr_en,
  output logic                        sub_en,
  output logic                        ram_ctrl,
  output logic [1:0]                  wr_sel_eq,
  output logic [1:0]                  rd_sel_eq,
  output logic [n_bit_for_sample-1:0] eq_addr,
  output logic signed [DATA_W-1:0]    data_out_1,
  output logic signed [DATA_W-1:0]    data_out_2,
  output logic                        sat_flag
);

  localparam logic [n_bit_for_sample-1:0] K_LAST = n_bit_for_sample'(sample - 1);
  localparam logic [n_bit_for_sample-1:0] K_ONE  = n_bit_for_sample'(1);

  state_t                        state_r;
  logic [n_bit_for_sample-1:0]   k_r;
  logic signed [DATA_W-1:0]      coef_re_r [sample];
  logic signed [DATA_W-1:0]      coef_im_r [sample];
  logic                          mul_load_s;
  logic                          mul_sat_s;
  logic                          coef_open_s;

  // Multiplier loads in CALC; coefficient bank is writable only between frames
  always_comb begin
    mul_load_s  = (state_r == ST_CALC);
    coef_open_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
  end

  // Coefficient bank: unity after reset, updated only outside a frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < sample; i++) begin
        coef_re_r[i] <= COEF_UNITY;
        coef_im_r[i] <= 32'sd0;
      end
    end else if (coef_we && coef_open_s) begin
      coef_re_r[coef_addr] <= coef_re;
      coef_im_r[coef_addr] <= coef_im;
    end else begin
      for (int i = 0; i < sample; i++) begin
        coef_re_r[i] <= coef_re_r[i];
        coef_im_r[i] <= coef_im_r[i];
      end
    end
  end

  freq_eq_cmul_q #(
    .FRAC (COEF_FRAC)
  ) u_cmul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load_s),
    .a      (data_in_1),
    .b      (data_in_2),
    .c      (coef_re_r[k_r]),
    .d      (coef_im_r[k_r]),
    .res_re (data_out_1),
    .res_im (data_out_2),
    .sat    (mul_sat_s)
  );

  // Frame sequencer: state, bin index and the registered RAM handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      k_r       <= '0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
      sub_en    <= 1'b0;
      ram_ctrl  <= 1'b0;
      wr_sel_eq <= BANK_OUT;
      rd_sel_eq <= BANK_OUT;
      eq_addr   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      sub_en    <= 1'b0;
      rd_sel_eq <= BANK_OUT;
      wr_sel_eq <= BANK_OUT;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_READ;
            k_r       <= '0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
            ram_ctrl  <= 1'b1;
            eq_addr   <= '0;
            rd_sel_eq <= BANK_DFT;
            sub_en    <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          state_r <= ST_CALC;
        end
        ST_CALC: begin
          state_r   <= ST_WRITE;
          eq_addr   <= k_r;
          wr_sel_eq <= BANK_IDFT_IN;
          wr_en     <= 1'b1;
          sub_en    <= 1'b1;
        end
        ST_WRITE: begin
          sat_flag <= sat_flag | mul_sat_s;
          if (k_r == K_LAST) begin
            state_r  <= ST_DONE;
            done     <= 1'b1;
            ram_ctrl <= 1'b0;
          end else begin
            state_r   <= ST_READ;
            k_r       <= k_r + K_ONE;
            eq_addr   <= k_r + K_ONE;
            rd_sel_eq <= BANK_DFT;
            sub_en    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!start) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ram_ctrl <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_eq.sv
// Directed bench for freq_eq: a registered-read RAM model feeds the DFT
// bank, a write monitor captures the iDFT input bank, and each step
// compares against hand-computed values.
module tb_freq_eq;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [31:0] data_in_1 = 32'sd0;
  logic signed [31:0] data_in_2 = 32'sd0;
  logic               coef_we;
  logic [2:0]         coef_addr;
  logic signed [31:0] coef_re;
  logic signed [31:0] coef_im;
  logic               done;
  logic               wr_en;
  logic               sub_en;
  logic               ram_ctrl;
  logic [1:0]         wr_sel_eq;
  logic [1:0]         rd_sel_eq;
  logic [2:0]         eq_addr;
  logic signed [31:0] data_out_1;
  logic signed [31:0] data_out_2;
  logic               sat_flag;

  freq_eq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .data_in_1  (data_in_1),
    .data_in_2  (data_in_2),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_re    (coef_re),
    .coef_im    (coef_im),
    .done       (done),
    .wr_en      (wr_en),
    .sub_en     (sub_en),
    .ram_ctrl   (ram_ctrl),
    .wr_sel_eq  (wr_sel_eq),
    .rd_sel_eq  (rd_sel_eq),
    .eq_addr    (eq_addr),
    .data_out_1 (data_out_1),
    .data_out_2 (data_out_2),
    .sat_flag   (sat_flag)
  );

  always #5 clk = ~clk;

  logic signed [31:0] dft_re [8];
  logic signed [31:0] dft_im [8];
  logic signed [31:0] out_re [8];
  logic signed [31:0] out_im [8];
  int stamp [8] = '{default: 0};
  int wr_cnt  = 0;
  int bad_sel = 0;
  int errors  = 0;
  int checks  = 0;
  int cyc;
  int base;

  // RAM model: one-cycle registered read of the DFT bank
  always @(posedge clk) begin
    if (sub_en && rd_sel_eq == 2'b01) begin
      data_in_1 <= dft_re[eq_addr];
      data_in_2 <= dft_im[eq_addr];
    end
  end

  // Write monitor: captures iDFT-bank writes and orders them
  always @(posedge clk) begin
    if (wr_en) begin
      out_re[eq_addr] <= data_out_1;
      out_im[eq_addr] <= data_out_2;
      stamp[eq_addr]  <= wr_cnt + 1;
      wr_cnt          <= wr_cnt + 1;
      if (wr_sel_eq !== 2'b10) bad_sel <= bad_sel + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a frame at the current negedge and follows it to done.
  task automatic run_frame(input bit toggle, input bit calc_we);
    base  = wr_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0;
    cyc = 0;
    while (cyc < 100 && done !== 1'b1) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 2 && calc_we) begin
        coef_we = 1'b1; coef_addr = 3'd6; coef_re = 32'sd0; coef_im = 32'sd0;
      end
      if (cyc == 3) begin
        coef_we = 1'b0;
        chk("first_wr_en", {31'd0, wr_en}, 32'd1);
      end
      if (cyc == 9 && toggle) start = 1'b1;
      if (cyc == 14) start = 1'b0;
    end
    chk("done_latency", cyc, 32'd32);
    chk("write_count", wr_cnt - base, 32'd8);
    for (int i = 0; i < 8; i++) chk("addr_cover", {31'd0, stamp[i] > base}, 32'd1);
    chk("bank_sel", bad_sel, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    start = 1'b0; coef_we = 1'b0; coef_addr = 3'd0; coef_re = 32'sd0; coef_im = 32'sd0;
    for (int i = 0; i < 8; i++) begin
      dft_re[i] = i * 100;
      dft_im[i] = -i;
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    // Reset state
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_sub_en", {31'd0, sub_en}, 32'd0);
    chk("rst_ram_ctrl", {31'd0, ram_ctrl}, 32'd0);
    chk("rst_data_out_1", data_out_1, 32'd0);
    chk("rst_data_out_2", data_out_2, 32'd0);
    chk("rst_sat_flag", {31'd0, sat_flag}, 32'd0);
    chk("rst_addr_sel", {25'd0, eq_addr, rd_sel_eq, wr_sel_eq}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1: unity coefficients pass data through unchanged
    run_frame(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk("unity_re", out_re[i], i * 100);
      chk("unity_im", out_im[i], -i);
    end
    chk("unity_sat", {31'd0, sat_flag}, 32'd0);
    repeat (3) @(negedge clk);
    chk("done_hold", {31'd0, done}, 32'd1);
    chk("ram_ctrl_idle", {31'd0, ram_ctrl}, 32'd0);
    chk("data_hold", data_out_1, 32'd700);

    // 2: coefficient j on bin 2 rotates (3,5) to (-5,3)
    coef_we = 1'b1; coef_addr = 3'd2; coef_re = 32'sd0; coef_im = 32'sd1024;
    @(negedge clk);
    coef_we = 1'b0;
    dft_re[2] = 32'sd3; dft_im[2] = 32'sd5;
    run_frame(1'b0, 1'b0);
    chk("rot_re", out_re[2], -32'sd5);
    chk("rot_im", out_im[2], 32'sd3);
    chk("rot_other_re", out_re[3], 32'sd300);
    chk("rot_other_im", out_im[1], -32'sd1);

    // 3: half-scale coefficient, written in the same cycle as start
    repeat (2) @(negedge clk);
    dft_re[0] = 32'sd3; dft_im[0] = -32'sd3;
    coef_we = 1'b1; coef_addr = 3'd0; coef_re = 32'sd512; coef_im = 32'sd0;
    run_frame(1'b0, 1'b0);
    chk("round_re_a", out_re[0], 32'sd2);
    chk("round_im_a", out_im[0], -32'sd1);
    repeat (2) @(negedge clk);
    dft_re[0] = 32'sd1; dft_im[0] = 32'sd0;
    run_frame(1'b0, 1'b0);
    chk("round_re_b", out_re[0], 32'sd1);
    chk("round_im_b", out_im[0], 32'sd0);

    // 4: saturation on bin 5, then sat_flag cleared by the next frame
    repeat (2) @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd5; coef_re = 32'sd2048; coef_im = 32'sd0;
    @(negedge clk);
    coef_we = 1'b0;
    dft_re[5] = 32'sh7FFFFFFF; dft_im[5] = 32'sh80000000;
    run_frame(1'b0, 1'b0);
    chk("sat_re", out_re[5], 32'h7FFFFFFF);
    chk("sat_im", out_im[5], 32'h80000000);
    chk("sat_flag_set", {31'd0, sat_flag}, 32'd1);
    repeat (2) @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd5; coef_re = 32'sd1024; coef_im = 32'sd0;
    @(negedge clk);
    coef_we = 1'b0;
    dft_re[5] = 32'sd500; dft_im[5] = -32'sd5;
    run_frame(1'b0, 1'b0);
    chk("sat_flag_clear", {31'd0, sat_flag}, 32'd0);
    chk("unsat_re", out_re[5], 32'sd500);

    // 5: coef write during CALC ignored, mid-frame start ignored
    repeat (2) @(negedge clk);
    run_frame(1'b1, 1'b1);
    chk("calc_we_re", out_re[6], 32'sd600);
    chk("calc_we_im", out_im[6], -32'sd6);

    // 6: reset in the middle of bin 3
    repeat (3) @(negedge clk);
    coef_we = 1'b1; coef_addr = 3'd4; coef_re = 32'sd0; coef_im = 32'sd0;
    @(negedge clk);
    coef_we = 1'b0;
    base  = wr_cnt;
    start = 1'b1;
    repeat (13) @(posedge clk);
    #1;
    start = 1'b0;
    rst   = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_sub_en", {31'd0, sub_en}, 32'd0);
    chk("mid_rst_ram_ctrl", {31'd0, ram_ctrl}, 32'd0);
    chk("mid_rst_data", data_out_1 | data_out_2, 32'd0);
    chk("mid_rst_addr", {29'd0, eq_addr}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_rst_writes", wr_cnt - base, 32'd3);
    run_frame(1'b0, 1'b0);
    chk("post_rst_coef4_re", out_re[4], 32'sd400);
    chk("post_rst_coef4_im", out_im[4], -32'sd4);
    chk("post_rst_coef2_re", out_re[2], 32'sd3);
    chk("post_rst_coef0_re", out_re[0], 32'sd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_eq.md
Name: freq_eq

Overview:
- Frequency-domain equaliser between the forward DFT and the iDFT stage.
- After `start`, it walks every bin k = 0..sample-1 of the DFT result bank in the shared RAM. Each bin is multiplied by a programmable complex Q10 coefficient and written to the iDFT input bank.
- `done` is raised on completion and is used directly as the iDFT `start`.
- It uses the same RAM-arbiter handshake as the iDFT stage: `ram_ctrl`, `sub_en`, `wr_en`, read/write bank selects and a shared address.

Parameters:
- sample, 8, number of bins per frame.
- n_bit_for_sample, 3, log2(sample); address width.
- COEF_FRAC, 10, fractional bits of coefficients (1.0 = 1024).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  level; a rising level seen in IDLE starts a frame.
- data_in_1  in  32 signed  RAM read data, real part.
- data_in_2  in  32 signed  RAM read data, imaginary part.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  n_bit_for_sample  coefficient index (bin).
- coef_re  in  32 signed  coefficient real part, Q(COEF_FRAC).
- coef_im  in  32 signed  coefficient imaginary part, Q(COEF_FRAC).
- done  out  1  frame complete.
- wr_en  out  1  RAM write pulse.
- sub_en  out  1  RAM access request to the arbiter.
- ram_ctrl  out  1  block owns the RAM.
- wr_sel_eq  out  2  write bank select.
- rd_sel_eq  out  2  read bank select.
- eq_addr  out  n_bit_for_sample  RAM address.
- data_out_1  out  32 signed  write data, real part.
- data_out_2  out  32 signed  write data, imaginary part.
- sat_flag  out  1  sticky; set if any result saturated in the current frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, k=0.
  - All outputs 0.
  - All coefficients = 1024+0j (unity).
  - A reset mid-frame abandons the frame; no further writes occur.
- Per-cycle defaults: wr_en=0, sub_en=0, rd_sel_eq=00, wr_sel_eq=00.
- ram_ctrl = 1 in READ/WAIT/CALC/WRITE, 0 in IDLE/DONE.
- IDLE:
  - start=1 → READ, k=0, done=0, sat_flag=0.
- READ:
  - eq_addr=k, rd_sel_eq=01 (DFT output bank), sub_en=1.
  - → WAIT.
- WAIT:
  - Covers the RAM read latency.
  - → CALC.
- CALC:
  - Samples data_in_1/2 (a+jb) and coefficient k (c+jd).
  - Registers the full-width products: re = a*c - b*d, im = a*d + b*c (65-bit signed).
  - → WRITE.
- WRITE:
  - Computes r = (p + 2^(COEF_FRAC-1)) >>> COEF_FRAC (round half up, arithmetic shift).
  - Saturates r to [-2^31, 2^31-1]; any clamp sets sat_flag.
  - data_out_1/2 = the two saturated results.
  - eq_addr=k, wr_sel_eq=10 (iDFT input bank), wr_en=1, sub_en=1.
  - If k == sample-1 → DONE with done=1; else k=k+1 → READ.
- Timing: exactly 4 cycles per bin.
  - The first wr_en occurs in the 4th cycle after the start-sampling edge.
  - done rises 4*sample cycles after that edge.
- DONE:
  - done and data_out_1/2 are held.
  - start=0 → IDLE; done stays 1 until the next start.
- start asserted in READ/WAIT/CALC/WRITE is ignored; frames are never restarted mid-way.
- Coefficient write: coef_we=1 in IDLE or DONE writes coef[coef_addr] at the clock edge.
  - Ignored in any other state, so the frame uses a stable coefficient set.
  - coef_we and start in the same IDLE cycle: the write completes, and the new coefficient is used for its bin.
- Address wrap: k never exceeds sample-1; the last bin is sample-1.

Decomposition:
- Shared package:
  - State encodings IDLE/READ/WAIT/CALC/WRITE/DONE.
  - Bank select codes: BANK_DFT=01, BANK_IDFT_IN=10, BANK_OUT=00.
  - COEF_UNITY = 1024.
  - Saturation bounds.
- One sub-module, cmul_q: registered complex multiply plus round/shift/saturate, with a sat output.
  - Reusable by the DFT/iDFT twiddle paths.

Test Plan:
1. Unity default coefficients, bins k → (k*100, -k): written data equals read data exactly, 8 writes to addresses 0..7 with wr_sel_eq=10, done after 32 cycles, sat_flag=0.
2. coef[2]=0+1024j, bin 2 = (3,5) → written (-5,3); other bins unchanged.
3. Rounding with coef[0]=512+0j: bin (3,-3) → (2,-1); bin (1,0) → (1,0).
4. Saturation with coef[5]=2048+0j, bin 5 = (0x7FFFFFFF, 0x80000000) → (0x7FFFFFFF, 0x80000000), sat_flag=1; sat_flag clears on the next start.
5. coef_we pulsed while in CALC → coefficient unchanged; start toggled mid-frame → no restart, still 8 writes.
6. rst=0 at bin 3 → all outputs 0 immediately, no further wr_en, coefficients back to unity; a new start runs a full clean frame.
